// File: rtl/alu_arbiter_pkg.sv
// Shared opcode and compare-vector definitions for the ALU arbiter.
// Imported by the interface, the ALU and the arbiter top.
package alu_arbiter_pkg;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_AND  = 3'b000;
  localparam alu_op_t ALU_OR   = 3'b001;
  localparam alu_op_t ALU_ADD  = 3'b010;
  localparam alu_op_t ALU_CMP  = 3'b011;
  localparam alu_op_t ALU_SUB  = 3'b110;
  localparam alu_op_t ALU_SLTU = 3'b111;

  localparam int CMP_EQ   = 0;
  localparam int CMP_SLT  = 1;
  localparam int CMP_LT   = 2;
  localparam int CMP_SLTE = 3;
  localparam int CMP_LTE  = 4;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters and the ALU arbiter.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0;
  logic [31:0] req_a1;
  logic [31:0] req_b0;
  logic [31:0] req_b1;
  alu_op_t     req_ctl0;
  alu_op_t     req_ctl1;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_result0;
  logic [31:0] resp_result1;

  modport master (
    output req_valid,
    output req_a0, req_a1,
    output req_b0, req_b1,
    output req_ctl0, req_ctl1,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_result0, resp_result1
  );

  modport slave (
    input  req_valid,
    input  req_a0, req_a1,
    input  req_b0, req_b1,
    input  req_ctl0, req_ctl1,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_result0, resp_result1
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU shared by both requesters.
// Undefined opcodes produce zero.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     ctl,
  output logic [31:0] y
);

  logic       eq;
  logic       lt;
  logic       slt;
  logic [4:0] v;

  assign eq  = (a == b);
  assign lt  = (a < b);
  assign slt = ($signed(a) < $signed(b));

  always_comb begin
    v           = '0;
    v[CMP_EQ]   = eq;
    v[CMP_SLT]  = slt;
    v[CMP_LT]   = lt;
    v[CMP_SLTE] = slt | eq;
    v[CMP_LTE]  = lt | eq;
  end

  always_comb begin
    y = '0;
    case (ctl)
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_CMP:  y = {22'b0, ~v, v};
      ALU_SLTU: y = {31'b0, lt};
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter around one shared ALU, with a one-entry
// registered response slot and a grant counter per requester.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit FAIR  = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  alu_arbiter_if.slave     bus,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  logic [1:0]       can_take;
  logic [1:0]       elig;
  logic [1:0]       grant;
  logic [1:0]       acc;
  logic             last_grant;
  logic             sel;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  alu_op_t          alu_ctl;
  logic [31:0]      alu_y;
  logic [1:0]       rvalid;
  logic [31:0]      rdata [2];
  logic [CNT_W-1:0] cnt [2];

  // A full slot being drained this edge may be refilled on the same edge.
  assign can_take = ~rvalid | bus.resp_ready;
  assign elig     = bus.req_valid & can_take;

  always_comb begin
    grant = 2'b00;
    unique case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (FAIR && !last_grant) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  assign bus.req_ready = reset ? grant : 2'b00;
  assign acc           = bus.req_valid & bus.req_ready;

  assign sel     = grant[1];
  assign alu_a   = sel ? bus.req_a1   : bus.req_a0;
  assign alu_b   = sel ? bus.req_b1   : bus.req_b0;
  assign alu_ctl = sel ? bus.req_ctl1 : bus.req_ctl0;

  alu_arbiter_alu u_alu (
    .a   (alu_a),
    .b   (alu_b),
    .ctl (alu_ctl),
    .y   (alu_y)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      rvalid     <= 2'b00;
      last_grant <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        rdata[i] <= '0;
        cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          rdata[i]  <= alu_y;
          rvalid[i] <= 1'b1;
          cnt[i]    <= cnt[i] + CNT_W'(1);
        end else if (bus.resp_ready[i]) begin
          rvalid[i] <= 1'b0;
        end
      end
      if (acc[0]) begin
        last_grant <= 1'b0;
      end else if (acc[1]) begin
        last_grant <= 1'b1;
      end
    end
  end

  assign bus.resp_valid   = rvalid;
  assign bus.resp_result0 = rdata[0];
  assign bus.resp_result1 = rdata[1];
  assign grant_cnt0       = cnt[0];
  assign grant_cnt1       = cnt[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a FAIR=1 instance for most scenarios
// and a FAIR=0 instance alongside it for fixed-priority contention.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] cnt0;
  logic [15:0] cnt1;
  logic [15:0] fcnt0;
  logic [15:0] fcnt1;
  int          errors;
  int          checks;

  alu_arbiter_if bus ();
  alu_arbiter_if bus_fp ();

  alu_arbiter #(.FAIR(1'b1), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .grant_cnt0 (cnt0),
    .grant_cnt1 (cnt1)
  );

  alu_arbiter #(.FAIR(1'b0), .CNT_W(16)) dut_fp (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus_fp),
    .grant_cnt0 (fcnt0),
    .grant_cnt1 (fcnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.req_valid = 2'b11;
    bus_fp.req_valid = 2'b00;
    repeat (3) begin
      step();
      checks++;
      if (bus.req_ready !== 2'b00) begin
        errors++;
        $display("FAIL reset_ready: got %b want 00", bus.req_ready);
      end
      checks++;
      if (bus.resp_valid !== 2'b00) begin
        errors++;
        $display("FAIL reset_valid: got %b want 00", bus.resp_valid);
      end
      checks++;
      if ({bus.resp_result0, bus.resp_result1} !== 64'h0) begin
        errors++;
        $display("FAIL reset_results: got %h %h want 0 0",
                 bus.resp_result0, bus.resp_result1);
      end
      checks++;
      if ({cnt0, cnt1} !== 32'h0) begin
        errors++;
        $display("FAIL reset_cnt: got %0d %0d want 0 0", cnt0, cnt1);
      end
    end
  endtask

  task automatic test_single();
    reset = 1'b1;
    bus.req_valid = 2'b01;
    bus.resp_ready = 2'b00;
    bus.req_a0 = 32'd7;
    bus.req_b0 = 32'd5;
    bus.req_ctl0 = ALU_ADD;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_ready: got %b want 01", bus.req_ready);
    end
    step();
    checks++;
    if (bus.resp_valid !== 2'b01 || bus.resp_result0 !== 32'd12) begin
      errors++;
      $display("FAIL single_add: got v=%b r=%h want v=01 r=0000000c",
               bus.resp_valid, bus.resp_result0);
    end
    checks++;
    if (cnt0 !== 16'd1) begin
      errors++;
      $display("FAIL single_cnt: got %0d want 1", cnt0);
    end
    bus.req_a0 = 32'd5;
    bus.req_b0 = 32'd7;
    bus.req_ctl0 = ALU_SUB;
    #1;
    checks++;
    if (bus.req_ready !== 2'b00) begin
      errors++;
      $display("FAIL single_full_ready: got %b want 00", bus.req_ready);
    end
    step();
    checks++;
    if (bus.resp_valid !== 2'b01 || bus.resp_result0 !== 32'd12) begin
      errors++;
      $display("FAIL single_hold: got v=%b r=%h want v=01 r=0000000c",
               bus.resp_valid, bus.resp_result0);
    end
    bus.resp_ready = 2'b01;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_refill_ready: got %b want 01", bus.req_ready);
    end
    step();
    checks++;
    if (bus.resp_result0 !== 32'hFFFF_FFFE || cnt0 !== 16'd2) begin
      errors++;
      $display("FAIL single_sub: got r=%h cnt=%0d want fffffffe 2",
               bus.resp_result0, cnt0);
    end
    bus.req_valid = 2'b00;
    step();
    checks++;
    if (bus.resp_valid !== 2'b00 || bus.resp_result0 !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL single_drain: got v=%b r=%h want 00 fffffffe",
               bus.resp_valid, bus.resp_result0);
    end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_rdy;
    logic [31:0] exp_r;
    reset = 1'b0;
    step();
    reset = 1'b1;
    bus.req_valid = 2'b11;
    bus.resp_ready = 2'b11;
    bus_fp.req_valid = 2'b11;
    bus_fp.resp_ready = 2'b11;
    for (int i = 0; i < 8; i++) begin
      bus.req_a0 = 32'(i);
      bus.req_b0 = 32'd1;
      bus.req_ctl0 = ALU_ADD;
      bus.req_a1 = 32'(i) << 8;
      bus.req_b1 = 32'(i);
      bus.req_ctl1 = ALU_OR;
      bus_fp.req_a0 = bus.req_a0;
      bus_fp.req_b0 = bus.req_b0;
      bus_fp.req_ctl0 = bus.req_ctl0;
      bus_fp.req_a1 = bus.req_a1;
      bus_fp.req_b1 = bus.req_b1;
      bus_fp.req_ctl1 = bus.req_ctl1;
      exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++;
      if (bus.req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got %b want %b", i, bus.req_ready, exp_rdy);
      end
      checks++;
      if (bus_fp.req_ready !== 2'b01) begin
        errors++;
        $display("FAIL fp_grant[%0d]: got %b want 01", i, bus_fp.req_ready);
      end
      step();
      if (i % 2 == 0) begin
        exp_r = 32'(i) + 32'd1;
        checks++;
        if (bus.resp_result0 !== exp_r) begin
          errors++;
          $display("FAIL rr_res0[%0d]: got %h want %h", i, bus.resp_result0, exp_r);
        end
      end else begin
        exp_r = (32'(i) << 8) | 32'(i);
        checks++;
        if (bus.resp_result1 !== exp_r) begin
          errors++;
          $display("FAIL rr_res1[%0d]: got %h want %h", i, bus.resp_result1, exp_r);
        end
      end
    end
    checks++;
    if (cnt0 !== 16'd4 || cnt1 !== 16'd4) begin
      errors++;
      $display("FAIL rr_cnt: got %0d %0d want 4 4", cnt0, cnt1);
    end
    checks++;
    if (fcnt0 !== 16'd8 || fcnt1 !== 16'd0) begin
      errors++;
      $display("FAIL fp_cnt: got %0d %0d want 8 0", fcnt0, fcnt1);
    end
    bus_fp.req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_r;
    bus.req_valid = 2'b11;
    bus.resp_ready = 2'b01;
    bus.req_a1 = 32'd100;
    bus.req_b1 = 32'd23;
    bus.req_ctl1 = ALU_ADD;
    for (int i = 0; i < 3; i++) begin
      bus.req_a0 = 32'd16 + 32'(i);
      bus.req_b0 = 32'd0;
      bus.req_ctl0 = ALU_ADD;
      #1;
      checks++;
      if (bus.req_ready !== 2'b01) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got %b want 01", i, bus.req_ready);
      end
      step();
      exp_r = 32'd16 + 32'(i);
      checks++;
      if (bus.resp_result0 !== exp_r) begin
        errors++;
        $display("FAIL bp_res0[%0d]: got %h want %h", i, bus.resp_result0, exp_r);
      end
      checks++;
      if (bus.resp_valid[1] !== 1'b1 || bus.resp_result1 !== 32'h0000_0707) begin
        errors++;
        $display("FAIL bp_hold1[%0d]: got v=%b r=%h want 1 00000707",
                 i, bus.resp_valid[1], bus.resp_result1);
      end
    end
    bus.resp_ready = 2'b11;
    #1;
    checks++;
    if (bus.req_ready !== 2'b10) begin
      errors++;
      $display("FAIL bp_refill_ready: got %b want 10", bus.req_ready);
    end
    bus.req_valid = 2'b10;
    step();
    checks++;
    if (bus.resp_valid !== 2'b10 || bus.resp_result1 !== 32'd123) begin
      errors++;
      $display("FAIL bp_refill: got v=%b r=%h want 10 0000007b",
               bus.resp_valid, bus.resp_result1);
    end
    checks++;
    if (cnt0 !== 16'd7 || cnt1 !== 16'd5) begin
      errors++;
      $display("FAIL bp_cnt: got %0d %0d want 7 5", cnt0, cnt1);
    end
  endtask

  task automatic test_compare();
    logic [31:0] va [9];
    logic [31:0] vb [9];
    logic [2:0]  vc [9];
    logic [31:0] ve [9];
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'd1;  vc[0] = ALU_CMP;  ve[0] = 32'h0000_02AA;
    va[1] = 32'hFFFF_FFFF; vb[1] = 32'd1;  vc[1] = ALU_SLTU; ve[1] = 32'h0;
    va[2] = 32'd5;         vb[2] = 32'd5;  vc[2] = ALU_CMP;  ve[2] = 32'h0000_00D9;
    va[3] = 32'd1; vb[3] = 32'hFFFF_FFFF;  vc[3] = ALU_SLTU; ve[3] = 32'd1;
    va[4] = 32'd1; vb[4] = 32'hFFFF_FFFF;  vc[4] = ALU_CMP;  ve[4] = 32'h0000_0174;
    va[5] = 32'd6;         vb[5] = 32'd3;  vc[5] = 3'b100;   ve[5] = 32'h0;
    va[6] = 32'd6;         vb[6] = 32'd3;  vc[6] = 3'b101;   ve[6] = 32'h0;
    va[7] = 32'h0000_F0F0; vb[7] = 32'h0000_FF00; vc[7] = ALU_AND; ve[7] = 32'h0000_F000;
    va[8] = 32'h0000_F0F0; vb[8] = 32'h0000_FF00; vc[8] = ALU_OR;  ve[8] = 32'h0000_FFF0;
    bus.req_valid = 2'b01;
    bus.resp_ready = 2'b01;
    for (int i = 0; i < 9; i++) begin
      bus.req_a0 = va[i];
      bus.req_b0 = vb[i];
      bus.req_ctl0 = vc[i];
      #1;
      checks++;
      if (bus.req_ready !== 2'b01) begin
        errors++;
        $display("FAIL cmp_ready[%0d]: got %b want 01", i, bus.req_ready);
      end
      step();
      checks++;
      if (bus.resp_result0 !== ve[i]) begin
        errors++;
        $display("FAIL cmp_res[%0d] ctl=%b: got %h want %h",
                 i, vc[i], bus.resp_result0, ve[i]);
      end
    end
  endtask

  task automatic test_midreset();
    bus.req_valid = 2'b11;
    bus.resp_ready = 2'b00;
    step();
    step();
    checks++;
    if (bus.resp_valid !== 2'b11) begin
      errors++;
      $display("FAIL mr_full: got %b want 11", bus.resp_valid);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 2'b00) begin
      errors++;
      $display("FAIL mr_ready: got %b want 00", bus.req_ready);
    end
    step();
    checks++;
    if (bus.resp_valid !== 2'b00 || {cnt0, cnt1} !== 32'h0) begin
      errors++;
      $display("FAIL mr_clear: got v=%b cnt=%0d %0d want 00 0 0",
               bus.resp_valid, cnt0, cnt1);
    end
    checks++;
    if ({bus.resp_result0, bus.resp_result1} !== 64'h0) begin
      errors++;
      $display("FAIL mr_results: got %h %h want 0 0",
               bus.resp_result0, bus.resp_result1);
    end
    reset = 1'b1;
    bus.resp_ready = 2'b11;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL mr_first_tie: got %b want 01", bus.req_ready);
    end
    step();
    checks++;
    if (cnt0 !== 16'd1 || cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL mr_cnt: got %0d %0d want 1 0", cnt0, cnt1);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0;
    bus.req_valid = 2'b00;
    bus.resp_ready = 2'b00;
    bus.req_a0 = '0;
    bus.req_a1 = '0;
    bus.req_b0 = '0;
    bus.req_b1 = '0;
    bus.req_ctl0 = ALU_AND;
    bus.req_ctl1 = ALU_AND;
    bus_fp.req_valid = 2'b00;
    bus_fp.resp_ready = 2'b00;
    bus_fp.req_a0 = '0;
    bus_fp.req_a1 = '0;
    bus_fp.req_b0 = '0;
    bus_fp.req_b1 = '0;
    bus_fp.req_ctl0 = ALU_AND;
    bus_fp.req_ctl1 = ALU_AND;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_compare();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
